screen_sequencer: RTL and testbench

SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

---
 rtl/screen_pkg.sv | 25 ++
 rtl/frame_tick_gen.sv | 25 ++
 rtl/screen_sequencer.sv | 150 +++++++++++++++
 tb/tb_screen_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types and constants for the screen sequencer: state encoding,
// visible-window bounds of the 640x480 VGA timing and the splash gray.
package screen_pkg;

    typedef enum logic [1:0] {
        SPLASH = 2'b00,
        PLAY   = 2'b01,
        P1WIN  = 2'b10,
        P2WIN  = 2'b11
    } screen_state_t;

    localparam logic [15:0] H_VIS_MIN = 16'd144;
    localparam logic [15:0] H_VIS_MAX = 16'd783;
    localparam logic [15:0] V_VIS_MIN = 16'd35;
    localparam logic [15:0] V_VIS_MAX = 16'd514;

    localparam logic [11:0] GRAY_RGB = 12'h333;

    // True when the counter pair lies inside the visible window (inclusive).
    function automatic logic in_window(input logic [15:0] h, input logic [15:0] v);
        return (h >= H_VIS_MIN) && (h <= H_VIS_MAX) &&
               (v >= V_VIS_MIN) && (v <= V_VIS_MAX);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Decodes the VGA counters into a one-cycle frame_start pulse (H=0,V=0)
// and a registered visible-window flag aligned with the registered pixel.
module frame_tick_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] h_count,
    input  logic [15:0] v_count,
    output logic        frame_start,
    output logic        in_visible
);
    import screen_pkg::*;

    // The counters sit at 0,0 for exactly one cycle per frame.
    assign frame_start = (h_count == 16'd0) && (v_count == 16'd0);

    // Register the window test so it lines up with the registered pixel data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_visible <= 1'b0;
        end else begin
            in_visible <= in_window(h_count, v_count);
        end
    end

endmodule

// File: rtl/screen_sequencer.sv
// Screen sequencer: splash -> play -> win screen -> splash, switching only
// at frame boundaries, with a one-cycle registered RGB output path.
// Optional feature macro: SCREEN_WIN_BLINK_EN (blinks win screens to gray
// on frames where frame counter bit 4 is set; needs FRAME_CNT_W >= 5).
module screen_sequencer #(
    parameter int WIN_HOLD_FRAMES = 300,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] H_Counter_Value,
    input  logic [15:0] V_Counter_Value,
    input  logic        start_btn,
    input  logic        p1_win,
    input  logic        p2_win,
    input  logic [11:0] game_rgb,
    input  logic [11:0] p1_rgb,
    input  logic [11:0] p2_rgb,
    output logic [3:0]  Red,
    output logic [3:0]  Green,
    output logic [3:0]  Blue,
    output logic [1:0]  screen_sel
);
    import screen_pkg::*;

    localparam logic [FRAME_CNT_W-1:0] HOLD_LAST = FRAME_CNT_W'(WIN_HOLD_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] CNT_MAX   = '1;

    screen_state_t          state;
    screen_state_t          state_next;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic                   cnt_clear;
    logic                   cnt_inc;
    logic                   start_pend;
    logic                   p1_pend;
    logic                   p2_pend;
    logic                   frame_start;
    logic                   in_visible;
    logic                   in_win_state;
    logic [11:0]            pix_mux;
    logic [11:0]            rgb_q;

    frame_tick_gen u_tick (
        .clk         (clk),
        .reset_n     (reset_n),
        .h_count     (H_Counter_Value),
        .v_count     (V_Counter_Value),
        .frame_start (frame_start),
        .in_visible  (in_visible)
    );

    assign in_win_state = (state == P1WIN) || (state == P2WIN);

    // Sticky event flags; a frame boundary drops everything and keeps only
    // events arriving on that very cycle, so they act on the next boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_pend <= 1'b0;
            p1_pend    <= 1'b0;
            p2_pend    <= 1'b0;
        end else if (frame_start) begin
            start_pend <= start_btn && !in_win_state;
            p1_pend    <= p1_win;
            p2_pend    <= p2_win;
        end else begin
            start_pend <= start_pend || (start_btn && !in_win_state);
            p1_pend    <= p1_pend || p1_win;
            p2_pend    <= p2_pend || p2_win;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SPLASH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; transitions are evaluated only on frame_start.
    always_comb begin
        state_next = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        if (frame_start) begin
            case (state)
                SPLASH: begin
                    if (start_pend) state_next = PLAY;
                end
                PLAY: begin
                    if (p1_pend)      state_next = P1WIN;
                    else if (p2_pend) state_next = P2WIN;
                end
                P1WIN, P2WIN: begin
                    if (frame_cnt == HOLD_LAST) begin
                        state_next = SPLASH;
                        cnt_clear  = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: state_next = SPLASH;
            endcase
        end
    end

    // Win-hold frame counter, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (cnt_clear) begin
            frame_cnt <= '0;
        end else if (cnt_inc && (frame_cnt != CNT_MAX)) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    // Pixel source selected by the current state.
    always_comb begin
        pix_mux = GRAY_RGB;
        case (state)
            SPLASH:  pix_mux = GRAY_RGB;
            PLAY:    pix_mux = game_rgb;
            P1WIN:   pix_mux = p1_rgb;
            P2WIN:   pix_mux = p2_rgb;
            default: pix_mux = GRAY_RGB;
        endcase
`ifdef SCREEN_WIN_BLINK_EN
        if (in_win_state && frame_cnt[4]) begin
            pix_mux = GRAY_RGB;
        end
`endif
    end

    // Pixel register; blanking uses the window flag registered alongside it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= pix_mux;
        end
    end

    assign Red        = in_visible ? rgb_q[11:8] : 4'd0;
    assign Green      = in_visible ? rgb_q[7:4]  : 4'd0;
    assign Blue       = in_visible ? rgb_q[3:0]  : 4'd0;
    assign screen_sel = state;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer with a short win hold (4 frames).
// Frame boundaries are synthesised by driving H=V=0 for one cycle.
module tb_screen_sequencer;

    logic        clk;
    logic        reset_n;
    logic [15:0] h;
    logic [15:0] v;
    logic        start_btn;
    logic        p1_win;
    logic        p2_win;
    logic [11:0] game_rgb;
    logic [11:0] p1_rgb;
    logic [11:0] p2_rgb;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic [1:0]  screen_sel;

    int checks   = 0;
    int failures = 0;

    screen_sequencer #(
        .WIN_HOLD_FRAMES (4),
        .FRAME_CNT_W     (16)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .H_Counter_Value (h),
        .V_Counter_Value (v),
        .start_btn       (start_btn),
        .p1_win          (p1_win),
        .p2_win          (p2_win),
        .game_rgb        (game_rgb),
        .p1_rgb          (p1_rgb),
        .p2_rgb          (p2_rgb),
        .Red             (red),
        .Green           (green),
        .Blue            (blue),
        .screen_sel      (screen_sel)
    );

    // 10 ns pixel clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One frame boundary cycle, then back to a mid-frame visible position.
    task automatic frame_tick();
        @(negedge clk);
        h = 16'd0;
        v = 16'd0;
        @(negedge clk);
        h = 16'd300;
        v = 16'd200;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
    endtask

    // Reset values, applied asynchronously before any clock edge.
    task automatic test_reset();
        reset_n   = 1'b0;
        h         = 16'd300;
        v         = 16'd200;
        start_btn = 1'b0;
        p1_win    = 1'b0;
        p2_win    = 1'b0;
        game_rgb  = 12'h000;
        p1_rgb    = 12'h000;
        p2_rgb    = 12'h000;
        #1;
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_sel: got %b expected 00", screen_sel);
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL reset_rgb: got %h expected 000", {red, green, blue});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL idle_frame_after_reset: got %b expected 00", screen_sel);
        end
    endtask

    // Start pressed mid-frame waits for the next H=0,V=0 cycle.
    task automatic test_start_mid_frame();
        pulse_start();
        repeat (4) @(negedge clk);
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL start_waits_frame: got %b expected 00", screen_sel);
        end
        @(negedge clk);
        h = 16'd0;
        v = 16'd0;
        #1;
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL start_before_edge: got %b expected 00", screen_sel);
        end
        @(negedge clk);
        h = 16'd300;
        v = 16'd200;
        checks++;
        if (screen_sel !== 2'b01) begin
            failures++;
            $display("[TB] FAIL start_to_play: got %b expected 01", screen_sel);
        end
    endtask

    // Simultaneous wins give P1; hold lasts 4 frames and ignores start.
    task automatic test_both_wins_and_hold();
        @(negedge clk);
        p1_win = 1'b1;
        p2_win = 1'b1;
        @(negedge clk);
        p1_win = 1'b0;
        p2_win = 1'b0;
        frame_tick();
        checks++;
        if (screen_sel !== 2'b10) begin
            failures++;
            $display("[TB] FAIL both_wins_p1: got %b expected 10", screen_sel);
        end
        frame_tick();
        pulse_start();
        frame_tick();
        frame_tick();
        checks++;
        if (screen_sel !== 2'b10) begin
            failures++;
            $display("[TB] FAIL hold_frame3: got %b expected 10", screen_sel);
        end
        frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL hold_return_splash: got %b expected 00", screen_sel);
        end
        frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL start_ignored_in_hold: got %b expected 00", screen_sel);
        end
    endtask

    // A p2 event coincident with frame_start acts one frame later.
    task automatic test_coincident_p2();
        pulse_start();
        frame_tick();
        checks++;
        if (screen_sel !== 2'b01) begin
            failures++;
            $display("[TB] FAIL replay: got %b expected 01", screen_sel);
        end
        @(negedge clk);
        h      = 16'd0;
        v      = 16'd0;
        p2_win = 1'b1;
        @(negedge clk);
        h      = 16'd300;
        v      = 16'd200;
        p2_win = 1'b0;
        checks++;
        if (screen_sel !== 2'b01) begin
            failures++;
            $display("[TB] FAIL p2_coincident_deferred: got %b expected 01", screen_sel);
        end
        frame_tick();
        checks++;
        if (screen_sel !== 2'b11) begin
            failures++;
            $display("[TB] FAIL p2_next_frame: got %b expected 11", screen_sel);
        end
        p2_rgb = 12'h5A7;
        repeat (2) @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'h5A7) begin
            failures++;
            $display("[TB] FAIL p2_pixel: got %h expected 5a7", {red, green, blue});
        end
        repeat (4) frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL p2_hold_return: got %b expected 00", screen_sel);
        end
    endtask

    // Pixel mux, window blanking and one-cycle latency.
    task automatic test_pixel();
        game_rgb = 12'hFFF;
        @(negedge clk);
        h = 16'd400;
        v = 16'd300;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'h333) begin
            failures++;
            $display("[TB] FAIL splash_gray: got %h expected 333", {red, green, blue});
        end
        pulse_start();
        frame_tick();
        @(negedge clk);
        h = 16'd143;
        v = 16'd200;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL blank_h143: got %h expected 000", {red, green, blue});
        end
        h = 16'd200;
        v = 16'd100;
        #1;
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL latency_not_yet: got %h expected 000", {red, green, blue});
        end
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL play_visible: got %h expected fff", {red, green, blue});
        end
        h = 16'd200;
        v = 16'd515;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL blank_v515: got %h expected 000", {red, green, blue});
        end
        h = 16'd144;
        v = 16'd35;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL edge_144_35: got %h expected fff", {red, green, blue});
        end
        h = 16'd783;
        v = 16'd514;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'hFFF) begin
            failures++;
            $display("[TB] FAIL edge_783_514: got %h expected fff", {red, green, blue});
        end
        h = 16'd784;
        v = 16'd300;
        @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL blank_h784: got %h expected 000", {red, green, blue});
        end
        h = 16'd300;
        v = 16'd200;
    endtask

    // Asynchronous reset in the middle of a win hold, then a full clean hold.
    task automatic test_reset_mid_hold();
        @(negedge clk);
        p1_win = 1'b1;
        @(negedge clk);
        p1_win = 1'b0;
        frame_tick();
        p1_rgb = 12'hABC;
        repeat (2) @(negedge clk);
        checks++;
        if ({red, green, blue} !== 12'hABC) begin
            failures++;
            $display("[TB] FAIL p1_pixel: got %h expected abc", {red, green, blue});
        end
        frame_tick();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL async_reset_sel: got %b expected 00", screen_sel);
        end
        checks++;
        if ({red, green, blue} !== 12'h000) begin
            failures++;
            $display("[TB] FAIL async_reset_rgb: got %h expected 000", {red, green, blue});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL after_reset_idle: got %b expected 00", screen_sel);
        end
        pulse_start();
        frame_tick();
        @(negedge clk);
        p1_win = 1'b1;
        @(negedge clk);
        p1_win = 1'b0;
        frame_tick();
        repeat (3) frame_tick();
        checks++;
        if (screen_sel !== 2'b10) begin
            failures++;
            $display("[TB] FAIL counter_cleared_by_reset: got %b expected 10", screen_sel);
        end
        frame_tick();
        checks++;
        if (screen_sel !== 2'b00) begin
            failures++;
            $display("[TB] FAIL full_hold_after_reset: got %b expected 00", screen_sel);
        end
    endtask

    // Run all scenarios in order and print the summary.
    initial begin
        test_reset();
        test_start_mid_frame();
        test_both_wins_and_hold();
        test_coincident_p2();
        test_pixel();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
